// File: rtl/trace_frame_fifo.sv
// rtl/trace_frame_fifo.sv - frame-aware trace word FIFO between packer and SPI link
module trace_frame_fifo #(
    parameter int DEPTH_LOG2  = 6,
    parameter int FRAME_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           wr_data,
    input  logic                  wr_en,
    input  logic                  flush,
    input  logic                  tx_free,
    input  logic                  flags_clr,
    output logic [15:0]           tx_word,
    output logic                  transmitIn,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_L = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] FRAME_L = FRAME_WORDS[DEPTH_LOG2:0];

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr_next;
    logic [DEPTH_LOG2:0]   level_next;
    logic [15:0]           head_next;
    logic                  s1, s2, s3;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  pop_acc;
    logic                  ovf_set;
    logic                  und_set;

    // Decode accepts, flag sets and the next head word; flush discards both requests silently.
    always_comb begin
        pop         = s2 & ~s3;
        full        = (level == DEPTH_L);
        empty       = (level == '0);
        wr_acc      = ~flush & wr_en & (~full | pop);
        pop_acc     = ~flush & pop & ~empty;
        ovf_set     = ~flush & wr_en & full & ~pop;
        und_set     = ~flush & pop & empty;
        rd_ptr_next = rd_ptr;
        if (pop_acc) begin
            rd_ptr_next = rd_ptr + 1'b1;
        end
        level_next = level;
        if (wr_acc && !pop_acc) begin
            level_next = level + 1'b1;
        end else if (pop_acc && !wr_acc) begin
            level_next = level - 1'b1;
        end
        // The word being written this clk is not in mem yet; bypass it when it becomes the head.
        if (wr_acc && (rd_ptr_next == wr_ptr)) begin
            head_next = wr_data;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    // Bring tx_free into the clk domain and keep one extra stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tx_free;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, level and the registered head/frame-ready outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            tx_word    <= 16'h0000;
            transmitIn <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            tx_word    <= 16'h0000;
            transmitIn <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_next;
            level  <= level_next;
            // tx_word only moves on a state change so the asynchronous sampler sees it stable.
            if (wr_acc || pop_acc) begin
                tx_word    <= (level_next != '0) ? head_next : 16'h0000;
                transmitIn <= (level_next >= FRAME_L);
            end
        end
    end

    // Sticky error flags; a new event wins over a clear in the same clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (flags_clr) begin
                overflow <= 1'b0;
            end
            if (und_set) begin
                underrun <= 1'b1;
            end else if (flags_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule
